uart_tx_serializer: RTL
=======================

// Module: uart_tx_serializer
// PURPOSE
//  Byte-stream to 8N1 serial UART transmitter with a small input FIFO.
//  Drives a UART rx pin, e.g. the Microwatt user UART rx (mprj_io[5]).
//  Used as the bench-side stimulus source and reusable in user-project RTL.
//  Replaces hand-timed rx waveforms with a clocked, baud-accurate frame generator.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per serial bit (100 MHz / 115200 = 868)
//  FIFO_DEPTH    4    input FIFO entries; power of 2, >= 2
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst         in   1   asynchronous, active-high reset
//  in_data     in   8   byte to transmit
//  in_valid    in   1   in_data valid; accepted when in_valid && in_ready
//  in_ready    out  1   FIFO not full (registered)
//  ser_tx      out  1   serial output, idle high, LSB first
//  busy        out  1   high while a frame is on the line or FIFO non-empty
//  tx_done     out  1   one-cycle pulse at end of each frame's stop bit
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently queued
// BEHAVIOUR
//  Reset (async assert, sync release): ser_tx=1, in_ready=1, busy=0, tx_done=0,
//   fifo_count=0, state=IDLE, bit timer=0, FIFO pointers cleared.
//  Reset mid-frame aborts the frame: ser_tx returns high immediately, queue lost.
//  FIFO: push on in_valid && in_ready; in_ready = (count < FIFO_DEPTH) from
//   registered count; full blocks push even if a pop occurs that cycle.
//   Push and pop in same cycle: count unchanged, data order preserved.
//   Pointers wrap modulo FIFO_DEPTH.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE/START.
//   IDLE: if count != 0, pop head into shift reg, go START.
//   START: ser_tx=0 for CLKS_PER_BIT cycles.
//   DATA: 8 bits, bit 0 first, each CLKS_PER_BIT cycles; 3-bit index 0..7.
//   STOP: ser_tx=1 for CLKS_PER_BIT cycles; on last cycle pulse tx_done;
//    if FIFO non-empty pop and go START directly (back-to-back, no idle gap),
//    else go IDLE.
//  Bit timer: counts 0..CLKS_PER_BIT-1, advances bit at terminal count, resets
//   to 0 on each state entry. Width $clog2(CLKS_PER_BIT).
//  Latency: push accepted at edge N -> count visible N+1 -> pop at N+1 ->
//   ser_tx low from edge N+2. Frame = 10*CLKS_PER_BIT cycles (11 with parity).
//  ser_tx is a registered output; no combinational path from inputs.
//  busy = (state != IDLE) || (count != 0).
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state inserted between DATA and STOP,
//   ser_tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles;
//   frame is 8E1, 11 bit times.
//  Undefined: no PARITY state, 8N1, 10 bit times; no parity logic present.
// TESTING
//  CLKS_PER_BIT=868: push 0x37 ('7') -> ser_tx 0,1,1,1,0,1,1,0,0,1 each 868 clks;
//   ser_tx low 2 edges after push; tx_done pulses once at clk 8680 of frame.
//  Push 0x55,0xAA back-to-back -> two frames, no idle gap between stop and
//   second start; fifo_count 2->1->0; busy drops after second tx_done.
//  Hold in_valid with FIFO_DEPTH=4 -> 5 accepted (1 popped + 4 queued),
//   in_ready low while count==4; re-high one cycle after next pop; order kept.
//  Assert rst during DATA bit 3 of 0xF0 -> ser_tx=1, fifo_count=0 same cycle;
//   after release, no residual frame; push 0x01 transmits cleanly.
//  UART_TX_PARITY_EN: push 0x37 -> parity bit 1 before stop; push 0x03 -> 0;
//   frame length 9548 clks.
//  Loopback: feed ser_tx into a CLKS_PER_BIT-matched rx model, send 0x00..0xFF
//   -> all 256 bytes received in order, no framing errors.

Source files
------------

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Brief    : Byte-stream to 8N1 UART transmitter with a small input FIFO.
//            Define UART_TX_PARITY_EN for 8E1 frames (even parity bit).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        ser_tx,
   output logic                        busy,
   output logic                        tx_done,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int TMR_W = $clog2(CLKS_PER_BIT);

   localparam logic [PTR_W:0]   c_DEPTH    = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_START  = 3'd1;
   localparam logic [2:0] c_DATA   = 3'd2;
   localparam logic [2:0] c_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] c_PARITY = 3'd3;
`endif

   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic [2:0]       r_state;
   logic [TMR_W-1:0] r_timer;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             r_ser_tx;
   logic             r_tx_done;

   logic w_push;
   logic w_pop;
   logic w_tc;
   logic w_has_data;

   assign in_ready   = (r_count < c_DEPTH);
   assign w_push     = in_valid && in_ready;
   assign w_has_data = (r_count != '0);
   assign w_tc       = (r_timer == c_TMR_LAST);
   // Pop from IDLE, or at the end of a stop bit so frames run back-to-back.
   assign w_pop      = w_has_data && ((r_state == c_IDLE) || ((r_state == c_STOP) && w_tc));

   assign ser_tx     = r_ser_tx;
   assign tx_done    = r_tx_done;
   assign fifo_count = r_count;
   assign busy       = (r_state != c_IDLE) || w_has_data;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= c_IDLE;
         r_timer   <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx_done <= 1'b0;
      end else begin
         r_tx_done <= 1'b0;
         case (r_state)
            c_IDLE: begin
               r_timer <= '0;
               if (w_pop) begin
                  r_shift <= r_mem[r_rd_ptr];
                  r_state <= c_START;
               end
            end
            c_START: begin
               if (w_tc) begin
                  r_timer   <= '0;
                  r_bit_idx <= '0;
                  r_state   <= c_DATA;
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end
            c_DATA: begin
               if (w_tc) begin
                  r_timer <= '0;
                  if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= c_PARITY;
`else
                     r_state <= c_STOP;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            c_PARITY: begin
               if (w_tc) begin
                  r_timer <= '0;
                  r_state <= c_STOP;
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end
`endif
            c_STOP: begin
               if (w_tc) begin
                  r_timer   <= '0;
                  r_tx_done <= 1'b1;
                  if (w_pop) begin
                     r_shift <= r_mem[r_rd_ptr];
                     r_state <= c_START;
                  end else begin
                     r_state <= c_IDLE;
                  end
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end
            default: begin
               r_timer <= '0;
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   // Line level follows the state register, so it lags state entry by one clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ser_tx <= 1'b1;
      end else begin
         case (r_state)
            c_START:  r_ser_tx <= 1'b0;
            c_DATA:   r_ser_tx <= r_shift[r_bit_idx];
`ifdef UART_TX_PARITY_EN
            c_PARITY: r_ser_tx <= ^r_shift;
`endif
            default:  r_ser_tx <= 1'b1;
         endcase
      end
   end

endmodule
`default_nettype wire
